// File: rtl/bound_flasher_pkg.sv
// Shared types and default levels for the bound-flasher LED controller.
// led_bhv_e  : behaviour code sent to the LED counter.
// fsm_state_e: sequencing FSM states, 3-bit encoding.
package bound_flasher_pkg;

    typedef enum logic [1:0] {
        DECREASE = 2'b00,
        INCREASE = 2'b01,
        PASS     = 2'b11
    } led_bhv_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP_A = 3'd1,
        DN_A = 3'd2,
        UP_B = 3'd3,
        DN_B = 3'd4,
        UP_C = 3'd5,
        DN_C = 3'd6
    } fsm_state_e;

    localparam int unsigned LED_NUMBER_DEF = 16;
    localparam int unsigned LVL_LO_DEF     = 5;
    localparam int unsigned LVL_MID_DEF    = 10;

endpackage

// File: rtl/led_decoder.sv
// Count-to-thermometer decoder: led[i] = 1 iff i < count. Purely combinational.
// Ports:
//   count : in  CNT_W       number of glowing LEDs
//   led   : out LED_NUMBER  thermometer vector
module led_decoder #(
    parameter int unsigned LED_NUMBER = 16,
    parameter int unsigned CNT_W      = 5
) (
    input  logic [CNT_W-1:0]      count,
    output logic [LED_NUMBER-1:0] led
);

    always_comb begin
        led = '0;
        for (int unsigned i = 0; i < LED_NUMBER; i++) begin
            led[i] = (i < 32'(count));
        end
    end

endmodule

// File: rtl/bound_flasher_ctrl.sv
// Sequencing FSM for the bound-flasher LED counter. Drives the counter's behaviour
// code from the FSM state and the fed-back count, and decodes count into a
// thermometer LED vector.
// Ports:
//   div_clk : in  1               divided clock, shared with the counter
//   rst     : in  1               synchronous active-high reset
//   flick   : in  1               start / kickback request, level-sensitive
//   count   : in  LED_NUMBER_W+1  glowing-LED count from the counter
//   led_bhv : out 2               00 DECREASE, 01 INCREASE, 11 PASS
//   state   : out 3               current FSM state (debug)
//   led     : out LED_NUMBER      thermometer decode of count
// Optional: define FLICK_SYNC_EN to pass flick through a 2-flop synchronizer.
module bound_flasher_ctrl
    import bound_flasher_pkg::*;
#(
    parameter int unsigned LED_NUMBER   = LED_NUMBER_DEF,
    parameter int unsigned LED_NUMBER_W = $clog2(LED_NUMBER),
    parameter int unsigned LVL_LO       = LVL_LO_DEF,
    parameter int unsigned LVL_MID      = LVL_MID_DEF
) (
    input  logic                    div_clk,
    input  logic                    rst,
    input  logic                    flick,
    input  logic [LED_NUMBER_W:0]   count,
    output logic [1:0]              led_bhv,
    output logic [2:0]              state,
    output logic [LED_NUMBER-1:0]   led
);

    localparam logic [LED_NUMBER_W:0] CNT_LO  = (LED_NUMBER_W + 1)'(LVL_LO);
    localparam logic [LED_NUMBER_W:0] CNT_MID = (LED_NUMBER_W + 1)'(LVL_MID);
    localparam logic [LED_NUMBER_W:0] CNT_HI  = (LED_NUMBER_W + 1)'(LED_NUMBER - 1);

    fsm_state_e state_q, state_d;
    led_bhv_e   bhv;
    logic       flick_use;

`ifdef FLICK_SYNC_EN
    logic flick_s1, flick_s2;

    always_ff @(posedge div_clk) begin
        if (rst) begin
            flick_s1 <= 1'b0;
            flick_s2 <= 1'b0;
        end else begin
            flick_s1 <= flick;
            flick_s2 <= flick_s1;
        end
    end

    assign flick_use = flick_s2;
`else
    assign flick_use = flick;
`endif

    always_ff @(posedge div_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Any cycle that takes a transition issues PASS, so the counter holds for
    // exactly one cycle at each turnaround.
    always_comb begin
        state_d = state_q;
        bhv     = PASS;
        case (state_q)
            IDLE: begin
                if (flick_use) state_d = UP_A;
            end
            UP_A: begin
                if (count >= CNT_HI)       state_d = DN_C;
                else if (count == CNT_LO)  state_d = DN_A;
                else                       bhv     = INCREASE;
            end
            DN_A: begin
                if (count == '0) state_d = UP_B;
                else             bhv     = DECREASE;
            end
            UP_B: begin
                if (count >= CNT_HI) begin
                    state_d = DN_C;
                end else if (flick_use && (count == CNT_LO || count == CNT_MID)) begin
                    state_d = DN_A;
                end else if (count == CNT_MID) begin
                    state_d = DN_B;
                end else begin
                    bhv = INCREASE;
                end
            end
            DN_B: begin
                // <= so a count already below the target still turns around.
                if (count <= CNT_LO) state_d = UP_C;
                else                 bhv     = DECREASE;
            end
            UP_C: begin
                if (count > CNT_HI) begin
                    state_d = DN_C;
                end else if (flick_use && (count == CNT_MID || count == CNT_HI)) begin
                    state_d = DN_B;
                end else if (count == CNT_HI) begin
                    state_d = DN_C;
                end else begin
                    bhv = INCREASE;
                end
            end
            DN_C: begin
                if (count == '0) state_d = IDLE;
                else             bhv     = DECREASE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign led_bhv = bhv;
    assign state   = state_q;

    led_decoder #(
        .LED_NUMBER (LED_NUMBER),
        .CNT_W      (LED_NUMBER_W + 1)
    ) u_led_decoder (
        .count (count),
        .led   (led)
    );

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Directed bench for bound_flasher_ctrl with a behavioural LED counter closing the loop.
module tb_bound_flasher_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_UP_A = 3'd1, S_DN_A = 3'd2, S_UP_B = 3'd3,
                           S_DN_B = 3'd4, S_UP_C = 3'd5, S_DN_C = 3'd6;
`ifdef FLICK_SYNC_EN
    localparam int START_LAT = 3;
`else
    localparam int START_LAT = 1;
`endif

    logic        div_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        flick   = 1'b0;
    logic [4:0]  count;
    logic [1:0]  led_bhv;
    logic [2:0]  state;
    logic [15:0] led;

    int n_total = 0;
    int n_bad   = 0;
    int dec_at_0   = 0;
    int inc_at_top = 0;
    int bad_code   = 0;

    always #5 div_clk = ~div_clk;

    bound_flasher_ctrl dut (
        .div_clk (div_clk),
        .rst     (rst),
        .flick   (flick),
        .count   (count),
        .led_bhv (led_bhv),
        .state   (state),
        .led     (led)
    );

    // Counter model: applies the behaviour code at the next edge.
    always @(posedge div_clk) begin
        if (rst) count <= 5'd0;
        else if (led_bhv == 2'b01) count <= count + 5'd1;
        else if (led_bhv == 2'b00) count <= count - 5'd1;
    end

    always @(negedge div_clk) begin
        if (!rst) begin
            if (led_bhv == 2'b00 && count == 5'd0) dec_at_0++;
            if (led_bhv == 2'b01 && count >= 5'd15) inc_at_top++;
            if (led_bhv == 2'b10) bad_code++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge div_clk);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s);
        int n = 0;
        while (state !== s && n < 300) begin
            step();
            n++;
        end
        if (state !== s) check({tag, "_timeout"}, 32'(state), 32'(s));
    endtask

    task automatic wait_count(input string tag, input logic [2:0] s, input logic [4:0] c);
        int n = 0;
        while (!(state === s && count === c) && n < 300) begin
            step();
            n++;
        end
        if (!(state === s && count === c)) check({tag, "_timeout"}, 32'(count), 32'(c));
    endtask

    initial begin
        int          lat;
        int          cyc;
        logic [4:0]  turns[$];
        logic [4:0]  exp_turns[6];
        logic [15:0] led10;
        logic [15:0] led15;

        exp_turns = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        exp_turns[0] = 5'd5;  exp_turns[1] = 5'd0; exp_turns[2] = 5'd10;
        exp_turns[3] = 5'd5;  exp_turns[4] = 5'd15; exp_turns[5] = 5'd0;
        led10 = '0;
        led15 = '0;

        // Power-on reset
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check("rst_state", 32'(state), 32'(S_IDLE));
        check("rst_bhv", 32'(led_bhv), 32'h3);
        check("rst_led", 32'(led), 32'h0);
        step();
        check("idle_hold", 32'(state), 32'(S_IDLE));

        // Full run from a single-cycle flick
        flick = 1'b1;
        step();
        lat = 1;
        flick = 1'b0;
        while (state !== S_UP_A && lat < 10) begin
            step();
            lat++;
        end
        check("start_latency", 32'(lat), 32'(START_LAT));
        check("upa_count", 32'(count), 32'h0);
        check("upa_bhv", 32'(led_bhv), 32'h1);
        cyc = 0;
        while (state !== S_IDLE && cyc < 200) begin
            if (led_bhv == 2'b11) begin
                turns.push_back(count);
                if (count == 5'd10) led10 = led;
                if (count == 5'd15) led15 = led;
            end
            step();
            cyc++;
        end
        check("run_cycles", 32'(cyc), 32'd56);
        check("run_turns", 32'(turns.size()), 32'd6);
        for (int i = 0; i < 6 && i < turns.size(); i++) begin
            check($sformatf("turn%0d", i), 32'(turns[i]), 32'(exp_turns[i]));
        end
        check("led_at_10", 32'(led10), 32'h03ff);
        check("led_at_15", 32'(led15), 32'h7fff);
        check("run_end_count", 32'(count), 32'h0);
        check("run_end_led", 32'(led), 32'h0);

`ifndef FLICK_SYNC_EN
        // Kickback in UP_B at count 10, then in UP_C at count 15
        flick = 1'b1;
        step();
        flick = 1'b0;
        wait_count("kb_b_wait", S_UP_B, 5'd10);
        flick = 1'b1;
        check("kb_b_bhv", 32'(led_bhv), 32'h3);
        step();
        flick = 1'b0;
        check("kb_b_state", 32'(state), 32'(S_DN_A));
        wait_state("kb_b_redo", S_UP_B);
        check("kb_b_floor", 32'(count), 32'h0);
        wait_state("kb_b_peak", S_DN_B);
        check("kb_b_repeak", 32'(count), 32'd10);
        wait_count("kb_c_wait", S_UP_C, 5'd15);
        flick = 1'b1;
        step();
        flick = 1'b0;
        check("kb_c_state", 32'(state), 32'(S_DN_B));
        check("kb_c_count", 32'(count), 32'd15);
        wait_state("kb_c_resume", S_UP_C);
        check("kb_c_floor", 32'(count), 32'd5);
        wait_state("kb_c_done", S_IDLE);
        check("kb_c_end", 32'(count), 32'h0);
`endif

        // flick held through UP_A and DN_A must not perturb the ramps
        flick = 1'b1;
        wait_state("ign_upa", S_UP_A);
        wait_state("ign_dna", S_DN_A);
        check("ign_dna_count", 32'(count), 32'd5);
        wait_state("ign_upb", S_UP_B);
        check("ign_upb_count", 32'(count), 32'h0);
        flick = 1'b0;

        // Reset in the middle of UP_C
        wait_count("mid_wait", S_UP_C, 5'd8);
        rst = 1'b1;
        step(); step();
        check("mid_rst_state", 32'(state), 32'(S_IDLE));
        check("mid_rst_bhv", 32'(led_bhv), 32'h3);
        check("mid_rst_count", 32'(count), 32'h0);
        check("mid_rst_led", 32'(led), 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_idle", 32'(state), 32'(S_IDLE));

        check("no_dec_at_0", 32'(dec_at_0), 32'h0);
        check("no_inc_at_top", 32'(inc_at_top), 32'h0);
        check("no_bad_code", 32'(bad_code), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
